// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, the default DM depth and the M_DM_op codes.
// No logic; imported by dm_arbiter and dm_arb_burst_ctr.
package dm_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int DM_DEPTH_WORDS = 3072;

    // M_DM_op encodings as seen by the DM; the arbiter only forwards them
    localparam logic [1:0] DM_OP_WORD = 2'd0;
    localparam logic [1:0] DM_OP_HALF = 2'd1;
    localparam logic [1:0] DM_OP_BYTE = 2'd2;

endpackage

// File: rtl/dm_arb_burst_ctr.sv
// DMA burst address generator: base, beat and remaining-beat counters.
// Latency: beat address, last flag and range check are combinational from the counters.
// Backpressure: advances only when the arbiter grants the beat (adv).
module dm_arb_burst_ctr
    import dm_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int LEN_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             adv,
    input  logic [31:0]      base_in,
    input  logic [LEN_W-1:0] len_in,
    output logic [31:0]      beat_addr,
    output logic             pend,
    output logic             last,
    output logic             in_range
);

    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

    logic [31:0]      base_q, base_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] rem_q,  rem_d;

    // Load a new burst or step past the granted beat
    always_comb begin
        base_d = base_q;
        beat_d = beat_q;
        rem_d  = rem_q;
        if (load) begin
            base_d = base_in;
            beat_d = '0;
            rem_d  = len_in;
        end else if (adv) begin
            beat_d = beat_q + 1'b1;
            rem_d  = rem_q - 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            beat_q <= '0;
            rem_q  <= '0;
        end else begin
            base_q <= base_d;
            beat_q <= beat_d;
            rem_q  <= rem_d;
        end
    end

    // Address wraps modulo 2^32; range check uses the whole word index, not just [13:2]
    always_comb begin
        beat_addr = base_q + {{(30-LEN_W){1'b0}}, beat_q, 2'b00};
        in_range  = (beat_addr[31:2] < DEPTH_IDX);
        pend      = (rem_q != '0);
        last      = (rem_q == LEN_W'(1));
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port DM arbiter: CPU M stage passes through, DMA bursts drain on free cycles.
// Latency: CPU access 0 cycles; first DMA beat 1 cycle after latch; done 1 cycle after last beat.
// Backpressure: cpu_stall when DMA takes the cycle; optional starvation guard (DM_ARB_STARVE_GUARD_EN).
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS  = DM_DEPTH_WORDS,
    parameter int LEN_W        = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [1:0]       cpu_op,
    input  logic [31:0]      cpu_pc,
    output logic             cpu_stall,
    output logic [31:0]      cpu_rdata,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [31:0]      dma_addr,
    input  logic [LEN_W-1:0] dma_len,
    input  logic [31:0]      dma_wdata,
    output logic             dma_beat,
    output logic [31:0]      dma_rdata,
    output logic             dma_busy,
    output logic             dma_done,
    output logic             dma_err,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic             dm_we,
    output logic [1:0]       dm_op,
    output logic [31:0]      dm_pc,
    input  logic [31:0]      dm_rdata
);

    arb_state_t state_q, state_d;
    logic       lat_we_q, lat_we_d;
    logic       err_seen_q, err_seen_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic        load;
    logic        dma_grant;
    logic        cpu_grant;
    logic        guard_force;
    logic [31:0] beat_addr;
    logic        pend;
    logic        last;
    logic        in_range;

    dm_arb_burst_ctr #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LEN_W       (LEN_W)
    ) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .adv       (dma_grant),
        .base_in   (dma_addr),
        .len_in    (dma_len),
        .beat_addr (beat_addr),
        .pend      (pend),
        .last      (last),
        .in_range  (in_range)
    );

    assign dma_grant = (state_q == ST_BURST) & pend & (~cpu_req | guard_force);
    assign cpu_grant = cpu_req & ~dma_grant;

`ifdef DM_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait_q, wait_d;

    assign guard_force = (wait_q == WAIT_MAX);

    // Count consecutive CPU wins while a burst is open; any DMA grant resets the run
    always_comb begin
        wait_d = wait_q;
        if (state_q != ST_BURST || dma_grant) begin
            wait_d = '0;
        end else if (cpu_grant && wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    // CPU has strict priority; DMA only sees cycles without cpu_req
    assign guard_force = 1'b0;
`endif

    // Burst FSM: latch in IDLE, finish on last granted beat or immediately for len=0
    always_comb begin
        state_d    = state_q;
        lat_we_d   = lat_we_q;
        err_seen_d = err_seen_q;
        load       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_req) begin
                    state_d    = ST_BURST;
                    load       = 1'b1;
                    lat_we_d   = dma_we;
                    err_seen_d = 1'b0;
                end
            end
            ST_BURST: begin
                if (!pend) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = err_seen_q;
                end else if (dma_grant) begin
                    if (!in_range) begin
                        err_seen_d = 1'b1;
                    end
                    if (last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = err_seen_q | ~in_range;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and status registers; reset abandons any open burst without a done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lat_we_q   <= 1'b0;
            err_seen_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_we_q   <= lat_we_d;
            err_seen_q <= err_seen_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // DM port mux; everything forced low while reset is held
    always_comb begin
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_we     = 1'b0;
        dm_op     = '0;
        dm_pc     = '0;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        dma_beat  = 1'b0;
        dma_rdata = '0;
        if (reset) begin
            cpu_stall = cpu_req & dma_grant;
            if (dma_grant) begin
                dma_beat  = 1'b1;
                dm_addr   = beat_addr;
                dm_wdata  = dma_wdata;
                dm_we     = lat_we_q & in_range;
                dma_rdata = in_range ? dm_rdata : '0;
            end else if (cpu_grant) begin
                dm_addr   = cpu_addr;
                dm_wdata  = cpu_wdata;
                dm_we     = cpu_we;
                dm_op     = cpu_op;
                dm_pc     = cpu_pc;
                cpu_rdata = dm_rdata;
            end
        end
    end

    assign dma_busy = (state_q == ST_BURST);
    assign dma_done = done_q;
    assign dma_err  = err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc;
    logic [1:0]  cpu_op;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic [4:0]  dma_len;
    logic        dma_beat, dma_busy, dma_done, dma_err;
    logic [31:0] dma_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
    logic        dm_we;
    logic [1:0]  dm_op;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_op(cpu_op), .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_beat(dma_beat), .dma_rdata(dma_rdata),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_op(dm_op),
        .dm_pc(dm_pc), .dm_rdata(dm_rdata)
    );

    // Behavioural DM: combinational read, write at posedge, 12-bit aliased index
    assign dm_rdata = mem[dm_addr[13:2]];
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[13:2]] <= dm_wdata;
    end

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic [1:0]  co;
        logic [31:0] cp;
        logic        dr, dw;
        logic [31:0] da;
        logic [4:0]  dl;
        logic [31:0] dd;
        logic        e_stall, e_beat, e_we;
        logic [31:0] e_addr;
        logic [1:0]  e_op;
        logic [31:0] e_pc, e_crd, e_drd;
        logic        e_busy, e_done, e_err;
    } vec_t;

    vec_t vec [0:22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_op = 0; cpu_pc = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, 32'(cpu_stall), 0);
        chk({tag, " beat"},  32'(dma_beat), 0);
        chk({tag, " dm_we"}, 32'(dm_we), 0);
        chk({tag, " dm_addr"}, dm_addr, 0);
        chk({tag, " dm_wdata"}, dm_wdata, 0);
        chk({tag, " dm_op"}, 32'(dm_op), 0);
        chk({tag, " dm_pc"}, dm_pc, 0);
        chk({tag, " cpu_rdata"}, cpu_rdata, 0);
        chk({tag, " dma_rdata"}, dma_rdata, 0);
        chk({tag, " busy"}, 32'(dma_busy), 0);
        chk({tag, " done"}, 32'(dma_done), 0);
        chk({tag, " err"}, 32'(dma_err), 0);
    endtask

    initial begin
        int beats;
        bit seen_done;
        bit bad_pulse;
        logic exp_stall;

        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'hC00] = 32'h5555AAAA;   // aliased under index 3072; out-of-range reads must return 0

        // cr cw ca cd co cp | dr dw da dl dd | stall beat we addr op pc crd drd busy done err
        vec[0]  = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'h0,    0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,0,0};
        vec[1]  = '{1,1,32'h10,32'hDEADBEEF,2'd0,32'h400, 0,0,32'h0,5'd0,32'h0, 0,0,1,32'h10,2'd0,32'h400,32'h0,32'h0,0,0,0};
        vec[2]  = '{1,0,32'h10,32'h0,2'd2,32'h404,    0,0,32'h0,5'd0,32'h0,    0,0,0,32'h10,2'd2,32'h404,32'hDEADBEEF,32'h0,0,0,0};
        vec[3]  = '{0,0,32'h0,32'h0,2'd0,32'h0,       1,1,32'h100,5'd4,32'h0,  0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,0,0};
        vec[4]  = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hA0,   0,1,1,32'h100,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[5]  = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hA1,   0,1,1,32'h104,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[6]  = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hA2,   0,1,1,32'h108,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[7]  = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hA3,   0,1,1,32'h10C,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[8]  = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'h0,    0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,1,0};
        vec[9]  = '{1,0,32'h104,32'h0,2'd0,32'h408,   0,0,32'h0,5'd0,32'h0,    0,0,0,32'h104,2'd0,32'h408,32'hA1,32'h0,0,0,0};
        vec[10] = '{0,0,32'h0,32'h0,2'd0,32'h0,       1,0,32'h10,5'd1,32'h0,   0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,0,0};
        vec[11] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'h0,    0,1,0,32'h10,2'd0,32'h0,32'h0,32'hDEADBEEF,1,0,0};
        vec[12] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'h0,    0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,1,0};
        vec[13] = '{0,0,32'h0,32'h0,2'd0,32'h0,       1,1,32'h0,5'd0,32'h0,    0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,0,0};
        vec[14] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'h0,    0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[15] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'h0,    0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,1,0};
        vec[16] = '{0,0,32'h0,32'h0,2'd0,32'h0,       1,1,32'h2FF8,5'd4,32'h0, 0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,0,0};
        vec[17] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hB0,   0,1,1,32'h2FF8,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[18] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hB1,   0,1,1,32'h2FFC,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[19] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hB2,   0,1,0,32'h3000,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[20] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'hB3,   0,1,0,32'h3004,2'd0,32'h0,32'h0,32'h0,1,0,0};
        vec[21] = '{0,0,32'h0,32'h0,2'd0,32'h0,       0,0,32'h0,5'd0,32'h0,    0,0,0,32'h0,2'd0,32'h0,32'h0,32'h0,0,1,1};
        vec[22] = '{1,0,32'h2FFC,32'h0,2'd0,32'h40C,  0,0,32'h0,5'd0,32'h0,    0,0,0,32'h2FFC,2'd0,32'h40C,32'hB1,32'h0,0,0,0};

        // Reset held with CPU traffic present: every output must be low
        idle_inputs();
        reset = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h1234; cpu_pc = 32'h80; cpu_op = 2'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 23; i++) begin
            cpu_req = vec[i].cr; cpu_we = vec[i].cw; cpu_addr = vec[i].ca; cpu_wdata = vec[i].cd;
            cpu_op = vec[i].co; cpu_pc = vec[i].cp;
            dma_req = vec[i].dr; dma_we = vec[i].dw; dma_addr = vec[i].da; dma_len = vec[i].dl;
            dma_wdata = vec[i].dd;
            @(negedge clk);
            chk($sformatf("r%0d stall", i), 32'(cpu_stall), 32'(vec[i].e_stall));
            chk($sformatf("r%0d beat", i),  32'(dma_beat),  32'(vec[i].e_beat));
            chk($sformatf("r%0d dm_we", i), 32'(dm_we),     32'(vec[i].e_we));
            chk($sformatf("r%0d dm_addr", i), dm_addr,      vec[i].e_addr);
            chk($sformatf("r%0d dm_op", i), 32'(dm_op),     32'(vec[i].e_op));
            chk($sformatf("r%0d dm_pc", i), dm_pc,          vec[i].e_pc);
            chk($sformatf("r%0d cpu_rdata", i), cpu_rdata,  vec[i].e_crd);
            chk($sformatf("r%0d dma_rdata", i), dma_rdata,  vec[i].e_drd);
            chk($sformatf("r%0d busy", i), 32'(dma_busy),   32'(vec[i].e_busy));
            chk($sformatf("r%0d done", i), 32'(dma_done),   32'(vec[i].e_done));
            chk($sformatf("r%0d err", i),  32'(dma_err),    32'(vec[i].e_err));
            @(posedge clk); #1;
        end
        chk("oor word 3070", mem[3070], 32'hB0);
        chk("oor alias 3072", mem[12'hC00], 32'h5555AAAA);
        chk("burst word 0x43", mem[12'h043], 32'hA3);

        // CPU held high through an 8-beat burst
        idle_inputs();
        cpu_req = 1; cpu_addr = 32'h20; cpu_pc = 32'h500;
        dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_len = 5'd8; dma_wdata = 32'hC0;
        @(negedge clk);
        chk("starve latch stall", 32'(cpu_stall), 0);
        @(posedge clk); #1;
        dma_req = 0;
        beats = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
`ifdef DM_ARB_STARVE_GUARD_EN
            exp_stall = (k % 5 == 0);
`else
            exp_stall = 1'b0;
`endif
            chk($sformatf("starve k%0d stall", k), 32'(cpu_stall), 32'(exp_stall));
            chk($sformatf("starve k%0d beat", k), 32'(dma_beat), 32'(exp_stall));
            if (dma_beat) beats++;
            @(posedge clk); #1;
        end
        cpu_req = 0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dma_beat) beats++;
            if (dma_done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("starve total beats", 32'(beats), 32'd8);
        chk("starve done seen", 32'(seen_done), 1);
        @(posedge clk); #1;

        // Reset mid-burst after 2 of 6 beats
        idle_inputs();
        dma_req = 1; dma_we = 1; dma_addr = 32'h300; dma_len = 5'd6; dma_wdata = 32'hD0;
        @(posedge clk); #1;
        dma_req = 0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            chk($sformatf("rst beat%0d addr", b), dm_addr, 32'h300 + 32'(4 * b));
            @(posedge clk); #1;
        end
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_pc = 32'h600; cpu_op = 2'd2;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        bad_pulse = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dma_done || dma_busy || dma_beat) bad_pulse = 1;
        end
        chk("post-reset quiet", 32'(bad_pulse), 0);
        @(posedge clk); #1;
        dma_req = 1; dma_we = 1; dma_addr = 32'h400; dma_len = 5'd1; dma_wdata = 32'hE0;
        @(posedge clk); #1;
        dma_req = 0;
        @(negedge clk);
        chk("fresh beat", 32'(dma_beat), 1);
        chk("fresh addr", dm_addr, 32'h400);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fresh done", 32'(dma_done), 1);
        chk("fresh err", 32'(dma_err), 0);
        chk("aborted burst word 2", mem[12'h0C2], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single-port data memory between the pipeline's M stage and a DMA/loader port. CPU accesses pass straight through in the cycle they are presented; DMA bursts are latched and drained one word per free DM cycle. A starvation guard bounds how long the CPU can lock DMA out. Sits between the M-stage register, the DMA master and the DM, and drives the DM's address, write-data, write-enable, op and PC inputs.

## Interface
- DEPTH_WORDS, 3072: number of DM words; valid word index 0..DEPTH_WORDS-1 (byte address bits [13:2]).
- LEN_W, 5: width of the DMA burst length.
- STARVE_LIMIT, 4: maximum consecutive CPU grants while a DMA beat is pending (guard build only).
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  M stage wants DM this cycle.
- cpu_we  in  1  M-stage store.
- cpu_addr  in  32  M-stage byte address.
- cpu_wdata  in  32  store data.
- cpu_op  in  2  M_DM_op, passed to DM unchanged.
- cpu_pc  in  32  M-stage PC, passed to DM for the write trace.
- cpu_stall  out  1  CPU not granted; M stage holds.
- cpu_rdata  out  32  DM read data; valid when cpu_req & ~cpu_stall.
- dma_req  in  1  burst request, level; sampled only in IDLE.
- dma_we  in  1  burst direction: 1 = write DM.
- dma_addr  in  32  burst base byte address, word aligned.
- dma_len  in  LEN_W  beat count; 0 = empty burst.
- dma_wdata  in  32  write data for the current beat.
- dma_beat  out  1  a DMA word is transferred this cycle.
- dma_rdata  out  32  read data; valid when dma_beat.
- dma_busy  out  1  burst latched and not finished.
- dma_done  out  1  one-cycle pulse at burst end.
- dma_err  out  1  one-cycle pulse with dma_done if any beat was out of range.
- dm_addr  out  32  to DM address.
- dm_wdata  out  32  to DM in.
- dm_we  out  1  to DM_write.
- dm_op  out  2  to M_DM_op.
- dm_pc  out  32  to DM PC.
- dm_rdata  in  32  DM out; combinational from dm_addr.

## Operation
- FSM states: IDLE and BURST. Registers: base address, beat counter (LEN_W), remaining count, wait counter, and the err-seen flag.
- IDLE: the CPU owns DM. If dma_req=1, latch dma_addr, dma_we and dma_len; clear the counters; go to BURST (dma_busy=1 from the next cycle). The CPU is still served in the latch cycle.
- BURST, per cycle: grant the CPU if cpu_req=1 and the guard allows it; otherwise grant DMA.
- DMA grant:
  - dma_beat=1 and dm_addr = base + 4*beat.
  - dm_we = latched we AND word index < DEPTH_WORDS.
  - beat increments.
  - An out-of-range beat still pulses dma_beat with dma_rdata=0 and sets err-seen.
- The final beat (beat = len-1) returns the FSM to IDLE. dma_done (and dma_err if err-seen) pulse in the following cycle.
- len=0: BURST lasts one cycle with no beat; dma_done pulses the cycle after.
- cpu_stall = cpu_req & (DMA granted). dm_op and dm_pc carry the CPU values when the CPU is granted, and 0 otherwise.
- Address arithmetic is 32-bit and wraps modulo 2^32. The range check uses the full word index (addr>>2), never only the aliased bits [13:2].
- Reset low at any time:
  - FSM goes to IDLE and all registers clear; the partial burst is abandoned with no dma_done.
  - While reset is low, every output is 0 (including dm_we and cpu_stall).

## Timing
- CPU access latency is 0 cycles: reads are combinational through DM; writes commit at the same posedge.
- The burst starts at the earliest one cycle after the latch cycle. A burst of N beats with no CPU traffic takes N+1 cycles from latch to the last beat. dma_done follows one cycle after the last beat.
- cpu_stall, dma_beat, dm_* and the rdata outputs are combinational from state plus inputs. dma_busy, dma_done and dma_err are registered.
- Simultaneous cpu_req and DMA pending: the CPU wins unless the guard forces DMA.
- dma_req held after dma_done: a new burst is latched in the first IDLE cycle.

## Configuration
- DM_ARB_STARVE_GUARD_EN defined:
  - The wait counter counts consecutive CPU grants in BURST.
  - When the count equals STARVE_LIMIT, the next cycle is granted to DMA regardless of cpu_req, and the counter clears on every DMA grant.
- Undefined: the CPU has strict priority, DMA only uses cycles with cpu_req=0, and the wait counter is not built.

## Structure
- Shared package holds: the FSM state encoding (IDLE, BURST), the DEPTH_WORDS default, and the M_DM_op encodings.
- One sub-module, dm_arb_burst_ctr: holds the base, beat and remaining counters; produces the beat address, the last-beat flag and the range check.
- Grant muxing and the FSM live in the top module.

## Test plan
- CPU only: store 0xDEADBEEF to 0x0000_0010 with cpu_op=0, then load it → cpu_stall=0 on both; cpu_rdata=0xDEADBEEF; dm_pc equals cpu_pc on the store.
- DMA write, len=4, base 0x100, no CPU traffic → beats write words 0x40..0x43 in cycles 1..4 after the latch; dma_done pulses at cycle 5; dma_busy falls with it.
- With the guard, cpu_req held high during an 8-beat burst, STARVE_LIMIT=4 → pattern of 4 CPU grants then 1 DMA beat (cpu_stall=1 on that cycle), repeated; the burst completes.
- Without the guard, same stimulus → no beats while cpu_req=1; the burst drains after cpu_req drops.
- DMA base 0x2FF8, len=4 → words 3070 and 3071 written; the beats at indices 3072 and 3073 have dm_we=0; dma_done and dma_err pulse together.
- Reset low mid-burst after 2 of 6 beats → all outputs 0 immediately; after release, state is IDLE, dma_done never pulses, and the next dma_req starts a fresh burst at beat 0.
